// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port, 1-cycle-latency word memory.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking; default is data-wins priority.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_W-1:0]     i_rdata,
   input  logic                  d_req,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wen,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  mem_enable,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wenable,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic                  owner
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state_q, state_d;
   logic                i_gnt_q, i_gnt_d;
   logic                i_rvalid_q, i_rvalid_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic                d_gnt_q, d_gnt_d;
   logic                d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                mem_en_q, mem_en_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]     mem_wen_q, mem_wen_d;
   logic                owner_q, owner_d;
   logic                is_rd_q, is_rd_d;
   logic                win;
`ifdef MEM_ARB_RR_EN
   // 1 = data wins the next tie; starts at 0 so fetch wins the first tie after reset
   logic                pri_q, pri_d;
`endif

   // win: 1 = data port, 0 = fetch port
`ifdef MEM_ARB_RR_EN
   assign win = d_req & (~i_req | pri_q);
`else
   assign win = d_req;
`endif

   always_comb begin
      state_d     = state_q;
      i_gnt_d     = 1'b0;
      d_gnt_d     = 1'b0;
      i_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      mem_en_d    = 1'b0;
      mem_wen_d   = '0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      owner_d     = owner_q;
      is_rd_d     = is_rd_q;
`ifdef MEM_ARB_RR_EN
      pri_d       = pri_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               owner_d  = win;
               mem_en_d = 1'b1;
               state_d  = ISSUE;
`ifdef MEM_ARB_RR_EN
               pri_d    = ~win;
`endif
               if (win) begin
                  d_gnt_d     = 1'b1;
                  mem_addr_d  = {2'b00, d_addr[ADDR_W-1:2]};
                  mem_wen_d   = d_wen;
                  mem_wdata_d = d_wdata;
                  is_rd_d     = (d_wen == '0);
               end else begin
                  i_gnt_d     = 1'b1;
                  mem_addr_d  = {2'b00, i_addr[ADDR_W-1:2]};
                  is_rd_d     = 1'b1;
               end
            end
         end
         ISSUE: state_d = RESP;
         RESP: begin
            // memory data is valid this cycle; stores complete without touching rdata
            state_d = IDLE;
            if (owner_q) begin
               d_rvalid_d = 1'b1;
               if (is_rd_q) d_rdata_d = mem_rdata;
            end else begin
               i_rvalid_d = 1'b1;
               if (is_rd_q) i_rdata_d = mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         i_gnt_q     <= 1'b0;
         i_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_gnt_q     <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wen_q   <= '0;
         owner_q     <= 1'b0;
         is_rd_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
         pri_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         i_gnt_q     <= i_gnt_d;
         i_rvalid_q  <= i_rvalid_d;
         i_rdata_q   <= i_rdata_d;
         d_gnt_q     <= d_gnt_d;
         d_rvalid_q  <= d_rvalid_d;
         d_rdata_q   <= d_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wen_q   <= mem_wen_d;
         owner_q     <= owner_d;
         is_rd_q     <= is_rd_d;
`ifdef MEM_ARB_RR_EN
         pri_q       <= pri_d;
`endif
      end
   end

   assign i_gnt       = i_gnt_q;
   assign i_rvalid    = i_rvalid_q;
   assign i_rdata     = i_rdata_q;
   assign d_gnt       = d_gnt_q;
   assign d_rvalid    = d_rvalid_q;
   assign d_rdata     = d_rdata_q;
   assign mem_enable  = mem_en_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_wenable = mem_wen_q;
   assign owner       = owner_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus tie, reset and streaming sequences.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wen = '0;
   logic [31:0] mem_rdata = '0;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_enable, busy, owner;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wenable;

   mem_port_arbiter dut (
      .CLK(CLK), .RSTN(RSTN),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wenable(mem_wenable), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        igt;
      logic        ivl;
      logic [31:0] ird;
      logic        dgt;
      logic        dvl;
      logic [31:0] drd;
      logic        men;
      logic [31:0] ma;
      logic [31:0] mw;
      logic [3:0]  mwe;
      logic        bsy;
      logic        own;
   } out_t;

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dwen;
      logic [31:0] mrd;
      out_t        exp;
   } vec_t;

   out_t obs;
   assign obs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_enable,
                 mem_addr, mem_wdata, mem_wenable, busy, owner};

   int nvec = 0;
   int nfail = 0;
   vec_t vt[16];

   function automatic out_t mko(input logic igt, input logic ivl, input logic [31:0] ird,
                                input logic dgt, input logic dvl, input logic [31:0] drd,
                                input logic men, input logic [31:0] ma, input logic [31:0] mw,
                                input logic [3:0] mwe, input logic bsy, input logic own);
      mko = {igt, ivl, ird, dgt, dvl, drd, men, ma, mw, mwe, bsy, own};
   endfunction

   function automatic vec_t mkv(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                input logic [31:0] daddr, input logic [31:0] dwdata,
                                input logic [3:0] dwen, input logic [31:0] mrd, input out_t e);
      vec_t v;
      v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
      v.dwdata = dwdata; v.dwen = dwen; v.mrd = mrd; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      i_req = 1'b0; d_req = 1'b0; d_wen = '0; mem_rdata = '0;
      RSTN = 1'b0;
      #12;
      chk("reset_state", 192'(obs), 192'(0));
      RSTN = 1'b1;
      @(posedge CLK); #1;
   endtask

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] CF = 32'hCAFEF00D;
   localparam logic [31:0] A5 = 32'hA5A5A5A5;

   initial begin
      // fetch 0x10
      vt[0]  = mkv(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b1,32'h4,32'h0,4'h0, 1'b1,1'b0));
      vt[1]  = mkv(1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b0,32'h4,32'h0,4'h0, 1'b1,1'b0));
      vt[2]  = mkv(1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, DB,
                   mko(1'b0,1'b1,DB, 1'b0,1'b0,32'h0, 1'b0,32'h4,32'h0,4'h0, 1'b0,1'b0));
      vt[3]  = mkv(1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b0,1'b0,32'h0, 1'b0,32'h4,32'h0,4'h0, 1'b0,1'b0));
      // full-word store to 0x00FFFF00
      vt[4]  = mkv(1'b0, 32'h0, 1'b1, 32'h00FFFF00, 32'h41, 4'hF, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b1,1'b0,32'h0, 1'b1,32'h003FFFC0,32'h41,4'hF, 1'b1,1'b1));
      vt[5]  = mkv(1'b0, 32'h0, 1'b0, 32'h00FFFF00, 32'h41, 4'hF, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b0,1'b0,32'h0, 1'b0,32'h003FFFC0,32'h41,4'h0, 1'b1,1'b1));
      vt[6]  = mkv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678,
                   mko(1'b0,1'b0,DB, 1'b0,1'b1,32'h0, 1'b0,32'h003FFFC0,32'h41,4'h0, 1'b0,1'b1));
      vt[7]  = mkv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b0,1'b0,32'h0, 1'b0,32'h003FFFC0,32'h41,4'h0, 1'b0,1'b1));
      // load from misaligned 0x103 -> word 0x40
      vt[8]  = mkv(1'b0, 32'h0, 1'b1, 32'h103, 32'h99, 4'h0, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b1,1'b0,32'h0, 1'b1,32'h40,32'h99,4'h0, 1'b1,1'b1));
      vt[9]  = mkv(1'b0, 32'h0, 1'b0, 32'h103, 32'h99, 4'h0, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b0,1'b0,32'h0, 1'b0,32'h40,32'h99,4'h0, 1'b1,1'b1));
      vt[10] = mkv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, CF,
                   mko(1'b0,1'b0,DB, 1'b0,1'b1,CF, 1'b0,32'h40,32'h99,4'h0, 1'b0,1'b1));
      vt[11] = mkv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b0,1'b0,CF, 1'b0,32'h40,32'h99,4'h0, 1'b0,1'b1));
      // fetch 0x7 -> word 1; mem_wdata keeps last data value
      vt[12] = mkv(1'b1, 32'h7, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b1,1'b0,DB, 1'b0,1'b0,CF, 1'b1,32'h1,32'h99,4'h0, 1'b1,1'b0));
      vt[13] = mkv(1'b0, 32'h7, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b0,1'b0,DB, 1'b0,1'b0,CF, 1'b0,32'h1,32'h99,4'h0, 1'b1,1'b0));
      vt[14] = mkv(1'b0, 32'h7, 1'b0, 32'h0, 32'h0, 4'h0, A5,
                   mko(1'b0,1'b1,A5, 1'b0,1'b0,CF, 1'b0,32'h1,32'h99,4'h0, 1'b0,1'b0));
      vt[15] = mkv(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   mko(1'b0,1'b0,A5, 1'b0,1'b0,CF, 1'b0,32'h1,32'h99,4'h0, 1'b0,1'b0));

      do_reset();
      for (int k = 0; k < 16; k++) begin
         i_req = vt[k].ireq; i_addr = vt[k].iaddr;
         d_req = vt[k].dreq; d_addr = vt[k].daddr;
         d_wdata = vt[k].dwdata; d_wen = vt[k].dwen; mem_rdata = vt[k].mrd;
         @(posedge CLK); #1;
         chk($sformatf("vec%0d", k), 192'(obs), 192'(vt[k].exp));
      end

      // both requesters held high for four accesses
      begin
         logic [3:0] own_seq;
         int ngnt, nrv, nig, bad;
         own_seq = '0; ngnt = 0; nrv = 0; nig = 0; bad = 0;
         do_reset();
         i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200; d_wen = 4'h0;
         for (int c = 0; c < 12; c++) begin
            mem_rdata = 32'h10000000 + 32'(c);
            @(posedge CLK); #1;
            if (i_gnt || d_gnt) begin
               if (ngnt < 4) own_seq[ngnt] = owner;
               if (i_gnt == d_gnt || d_gnt != owner) bad++;
               if (i_gnt) nig++;
               ngnt++;
            end
            if (i_rvalid || d_rvalid) begin
               if (i_rvalid == d_rvalid || d_rvalid != owner) bad++;
               nrv++;
            end
         end
         i_req = 1'b0; d_req = 1'b0;
         chk("tie_gnt_count", 192'(ngnt), 192'(4));
         chk("tie_rvalid_count", 192'(nrv), 192'(4));
         chk("tie_port_match", 192'(bad), 192'(0));
`ifdef MEM_ARB_RR_EN
         chk("tie_owner_seq", 192'(own_seq), 192'(4'b1010));
         chk("tie_i_gnt_count", 192'(nig), 192'(2));
`else
         chk("tie_owner_seq", 192'(own_seq), 192'(4'b1111));
         chk("tie_i_gnt_count", 192'(nig), 192'(0));
`endif
      end

      // reset asserted while the access is in ISSUE
      begin
         int nrv, lat;
         nrv = 0; lat = -1;
         do_reset();
         i_req = 1'b1; i_addr = 32'h20;
         @(posedge CLK); #1;
         chk("mid_gnt", 192'({i_gnt, busy}), 192'(2'b11));
         i_req = 1'b0;
         RSTN = 1'b0;
         #1;
         chk("mid_reset_outputs", 192'(obs), 192'(0));
         #1;
         RSTN = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            if (i_rvalid || d_rvalid || busy) nrv++;
         end
         chk("mid_no_rvalid", 192'(nrv), 192'(0));
         i_req = 1'b1; i_addr = 32'h24; mem_rdata = 32'h77;
         for (int c = 1; c <= 6; c++) begin
            @(posedge CLK); #1;
            if (i_gnt) i_req = 1'b0;
            if (i_rvalid && lat < 0) lat = c;
         end
         chk("post_reset_latency", 192'(lat), 192'(3));
         chk("post_reset_rdata", 192'({i_rdata, mem_addr}), 192'({32'h77, 32'h9}));
      end

      // back-to-back fetch stream
      begin
         logic [11:0] gmask, bmask;
         gmask = '0; bmask = '0;
         do_reset();
         i_req = 1'b1; i_addr = 32'h40; mem_rdata = 32'h5;
         for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            gmask[c] = i_gnt;
            bmask[c] = ~busy;
         end
         i_req = 1'b0;
         chk("b2b_gnt_pattern", 192'(gmask), 192'(12'h249));
         chk("b2b_idle_pattern", 192'(bmask), 192'(12'h924));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
